// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple-carry full-adder slice.
module add4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic c;

    always_comb begin
        c = ci;
        s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: walks NIBBLES operand nibbles through one add4_slice,
// holding the carry in a flop and assembling the sum in a right-shifting accumulator.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    nsa_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    // Only the already-finished nibbles need storing; the newest one is still
    // on the slice output, so acc is one nibble narrower than the result.
    logic [W-5:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            done_q, done_d;

    logic [3:0]      slice_s;
    logic            slice_c;
    logic [W-1:0]    acc_shift;

    add4_slice u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_c)
    );

    assign acc_shift = {slice_s, acc_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> NIBBLE_W;
                b_sh_d  = b_sh_q >> NIBBLE_W;
                acc_d   = acc_shift[W-1:4];
                carry_d = slice_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    sum_d   = acc_shift;
                    cout_d  = slice_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
